// File: rtl/video_fetch_sched.sv
// Video fetch scheduler: maps DRAM slot strobes to read requests, tracks outstanding
// byte-lane tags and assembles returned 16-bit words into a 32-bit renderer word.
module video_fetch_sched (
    input  logic        clk,
    input  logic        res,
    input  logic        c3,
    input  logic        line_start,
    input  logic        fetch_en,
    input  logic [4:0]  video_bw,
    input  logic [20:0] video_addr,
    input  logic [3:0]  fetch_sel,
    input  logic [1:0]  fetch_bsl,
    input  logic        fetch_stb,
    output logic        vid_req,
    output logic [20:0] vid_addr,
    output logic        video_next,
    input  logic [15:0] dram_rdata,
    input  logic        dram_rstrb,
    output logic [31:0] fetch_data,
    output logic        bw_miss,
    output logic        rtn_err
);

    localparam int unsigned SLOT_W  = 3;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned PTR_W   = 2;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned LANES   = 4;

    typedef struct packed {
        logic [3:0] sel;
        logic [1:0] bsl;
    } tag_t;

    logic [SLOT_W-1:0] slot_cnt;
    logic [SLOT_W-1:0] slot_mask;
    logic [SLOT_W-1:0] slot_pos;
    logic              req_slot;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              store;
    logic              pop_mem;
    tag_t              new_tag;
    tag_t              rtn_tag;
    tag_t              tag_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [7:0]        src_lo;
    logic [7:0]        src_hi;
    logic [31:0]       lane_src;
    logic [31:0]       asm_reg;
    logic [31:0]       asm_next;

    // Slot decode, FIFO handshake and return merge
    always_comb begin
        slot_mask  = video_bw[4] ? 3'd7 : (video_bw[3] ? 3'd3 : 3'd1);
        slot_pos   = slot_cnt & slot_mask;
        req_slot   = c3 && fetch_en && !line_start && (slot_pos < video_bw[2:0]);
        fifo_full  = (fifo_cnt == CNT_W'(DEPTH));
        fifo_empty = (fifo_cnt == '0);
        push       = req_slot && !fifo_full;
        new_tag    = '{sel: fetch_sel, bsl: fetch_bsl};
        // An empty FIFO with a same-clock push hands the new tag straight to the return
        pop        = dram_rstrb && (!fifo_empty || push);
        pop_mem    = dram_rstrb && !fifo_empty;
        store      = push && !(fifo_empty && dram_rstrb);
        rtn_tag    = fifo_empty ? new_tag : tag_mem[rd_ptr];
        src_lo     = rtn_tag.bsl[0] ? dram_rdata[15:8] : dram_rdata[7:0];
        src_hi     = rtn_tag.bsl[1] ? dram_rdata[15:8] : dram_rdata[7:0];
        lane_src   = {src_hi, src_lo, src_hi, src_lo};
        asm_next   = asm_reg;
        for (int n = 0; n < LANES; n++) begin
            if (pop && rtn_tag.sel[n]) begin
                asm_next[n*8 +: 8] = lane_src[n*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            slot_cnt   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            asm_reg    <= '0;
            fetch_data <= '0;
            vid_req    <= 1'b0;
            vid_addr   <= '0;
            video_next <= 1'b0;
            bw_miss    <= 1'b0;
            rtn_err    <= 1'b0;
        end else begin
            if (line_start) begin
                slot_cnt <= '0;
            end else if (c3 && fetch_en) begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
            end

            if (store) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_mem) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (store && !pop_mem) begin
                fifo_cnt <= fifo_cnt + CNT_W'(1);
            end else if (pop_mem && !store) begin
                fifo_cnt <= fifo_cnt - CNT_W'(1);
            end

            asm_reg <= asm_next;
            if (fetch_stb) begin
                fetch_data <= asm_next;
            end

            vid_req    <= push;
            video_next <= push;
            if (push) begin
                vid_addr <= video_addr;
            end
            bw_miss <= req_slot && fifo_full;
            if (dram_rstrb && !pop) begin
                rtn_err <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset; occupancy and pointers qualify it
    always_ff @(posedge clk) begin
        if (!res && store) begin
            tag_mem[wr_ptr] <= new_tag;
        end
    end

endmodule

// File: tb/tb_video_fetch_sched.sv
// Bench for video_fetch_sched: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue-based behavioural model.
module tb_video_fetch_sched;

    logic        clk = 1'b0;
    logic        res, c3, line_start, fetch_en, fetch_stb, dram_rstrb;
    logic [4:0]  video_bw;
    logic [20:0] video_addr;
    logic [3:0]  fetch_sel;
    logic [1:0]  fetch_bsl;
    logic [15:0] dram_rdata;
    logic        vid_req, video_next, bw_miss, rtn_err;
    logic [20:0] vid_addr;
    logic [31:0] fetch_data;

    always #5 clk = ~clk;

    video_fetch_sched dut (
        .clk        (clk),
        .res        (res),
        .c3         (c3),
        .line_start (line_start),
        .fetch_en   (fetch_en),
        .video_bw   (video_bw),
        .video_addr (video_addr),
        .fetch_sel  (fetch_sel),
        .fetch_bsl  (fetch_bsl),
        .fetch_stb  (fetch_stb),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .video_next (video_next),
        .dram_rdata (dram_rdata),
        .dram_rstrb (dram_rstrb),
        .fetch_data (fetch_data),
        .bw_miss    (bw_miss),
        .rtn_err    (rtn_err)
    );

    int checks   = 0;
    int failures = 0;
    int n_req    = 0;
    int n_miss   = 0;

    // Reference model state
    int          m_slot;
    logic [5:0]  m_q[$];
    logic [31:0] m_asm, m_fd;
    logic        m_err, e_req, e_next, e_miss;
    logic [20:0] e_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] a, input logic [5:0] t,
                                          input logic [15:0] d);
        logic [31:0] r;
        logic [3:0]  sel;
        logic [1:0]  bsl;
        r   = a;
        sel = t[5:2];
        bsl = t[1:0];
        for (int n = 0; n < 4; n++) begin
            if (sel[n]) r[n*8 +: 8] = bsl[n % 2] ? d[15:8] : d[7:0];
        end
        return r;
    endfunction

    task automatic model_update();
        int          period;
        int          need;
        logic        slot_req, full, issue, consumed;
        logic [5:0]  t;
        if (res) begin
            m_slot = 0; m_q.delete(); m_asm = '0; m_fd = '0; m_err = 1'b0;
            e_req = 1'b0; e_next = 1'b0; e_miss = 1'b0; e_addr = '0;
            return;
        end
        period   = video_bw[4] ? 8 : (video_bw[3] ? 4 : 2);
        need     = int'(video_bw[2:0]);
        slot_req = c3 && fetch_en && !line_start && ((m_slot % period) < need);
        full     = (m_q.size() == 4);
        issue    = slot_req && !full;
        consumed = 1'b0;
        if (dram_rstrb) begin
            if (m_q.size() > 0) begin
                t = m_q.pop_front();
                m_asm = merge(m_asm, t, dram_rdata);
            end else if (issue) begin
                m_asm = merge(m_asm, {fetch_sel, fetch_bsl}, dram_rdata);
                consumed = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
        if (issue && !consumed) m_q.push_back({fetch_sel, fetch_bsl});
        if (fetch_stb) m_fd = m_asm;
        e_req  = issue;
        e_next = issue;
        e_miss = slot_req && full;
        if (issue) e_addr = video_addr;
        if (line_start) m_slot = 0;
        else if (c3 && fetch_en) m_slot = (m_slot + 1) % 8;
    endtask

    // One clock: model predicts, edge happens, all outputs compared
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        chk("vid_req",    32'(vid_req),    32'(e_req));
        chk("video_next", 32'(video_next), 32'(e_next));
        chk("vid_addr",   32'(vid_addr),   32'(e_addr));
        chk("bw_miss",    32'(bw_miss),    32'(e_miss));
        chk("rtn_err",    32'(rtn_err),    32'(m_err));
        chk("fetch_data", fetch_data,      m_fd);
        if (vid_req) n_req++;
        if (bw_miss) n_miss++;
    endtask

    task automatic idle_inputs();
        res = 1'b0; c3 = 1'b0; line_start = 1'b0; fetch_stb = 1'b0; dram_rstrb = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        res = 1'b1;
        step();
        res = 1'b0;
    endtask

    // Clear the slot counter, then issue one request in position 0 with the given tag
    task automatic issue_req(input logic [3:0] sel, input logic [1:0] bsl);
        idle_inputs();
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        c3 = 1'b1; fetch_sel = sel; fetch_bsl = bsl;
        video_addr = 21'($urandom);
        step();
        c3 = 1'b0;
    endtask

    task automatic do_return(input logic [15:0] d, input logic stb);
        idle_inputs();
        dram_rstrb = 1'b1; dram_rdata = d; fetch_stb = stb;
        step();
        idle_inputs();
    endtask

    task automatic strobe();
        idle_inputs();
        fetch_stb = 1'b1;
        step();
        idle_inputs();
    endtask

    initial begin
        logic [1:0] hist;
        int         per_sel;
        int         need_sel;
        logic [1:0] per_code;
        logic [2:0] need_code;

        idle_inputs();
        res = 1'b1; fetch_en = 1'b1; video_bw = 5'b11_001; video_addr = '0;
        fetch_sel = '0; fetch_bsl = '0; dram_rdata = '0;
        step();
        chk("reset_fetch_data", fetch_data, 32'h0);
        chk("reset_vid_req",    32'(vid_req), 32'h0);
        res = 1'b0;

        // 1 of 8, c3 every clock, returns two clocks after each request
        hist = 2'b00;
        for (int i = 0; i < 24; i++) begin
            idle_inputs();
            c3 = 1'b1; video_addr = 21'($urandom);
            fetch_sel = 4'($urandom); fetch_bsl = 2'($urandom);
            dram_rstrb = hist[1]; dram_rdata = 16'($urandom);
            step();
            hist = {hist[0], vid_req};
        end
        chk("one_of_eight_reqs", 32'(n_req), 32'd3);
        chk("one_of_eight_miss", 32'(n_miss), 32'd0);

        // 4 of 8 with returns withheld: fifth request slot is a miss
        do_reset();
        video_bw = 5'b11_100;
        n_req = 0; n_miss = 0;
        for (int i = 0; i < 9; i++) begin
            idle_inputs();
            c3 = 1'b1; video_addr = 21'($urandom);
            step();
        end
        chk("four_of_eight_reqs", 32'(n_req), 32'd4);
        chk("four_of_eight_miss", 32'(n_miss), 32'd1);

        // Byte-lane steering and partial merges
        do_reset();
        video_bw = 5'b11_001;
        issue_req(4'b0011, 2'b10);
        do_return(16'hA55A, 1'b0);
        strobe();
        chk("lane_merge_a55a", fetch_data, 32'h0000_A55A);
        issue_req(4'b0001, 2'b11);
        do_return(16'h1234, 1'b0);
        strobe();
        chk("lane_merge_1234", fetch_data, 32'h0000_A512);

        // Unexpected return is dropped and flagged
        do_return(16'hFFFF, 1'b0);
        strobe();
        chk("empty_return_err",  32'(rtn_err), 32'd1);
        chk("empty_return_data", fetch_data,   32'h0000_A512);
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            step();
        end
        chk("rtn_err_sticky", 32'(rtn_err), 32'd1);

        // Strobe coincident with a return publishes the merged word
        do_reset();
        issue_req(4'b0011, 2'b00);
        issue_req(4'b1100, 2'b10);
        do_return(16'h0011, 1'b0);
        do_return(16'hBEEF, 1'b1);
        chk("stb_with_return", fetch_data, 32'hBEEF_1111);

        // Reset with three outstanding tags and a return in flight
        issue_req(4'b1111, 2'b00);
        issue_req(4'b1111, 2'b00);
        issue_req(4'b1111, 2'b00);
        idle_inputs();
        res = 1'b1; dram_rstrb = 1'b1; c3 = 1'b1;
        step();
        chk("reset_out_req",  32'(vid_req), 32'd0);
        chk("reset_out_err",  32'(rtn_err), 32'd0);
        chk("reset_out_data", fetch_data,   32'd0);
        do_return(16'h5555, 1'b1);
        chk("post_reset_return_err", 32'(rtn_err), 32'd1);
        chk("post_reset_return_data", fetch_data, 32'd0);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            res        = ($urandom_range(0, 199) == 0);
            c3         = ($urandom_range(0, 9) < 7);
            line_start = ($urandom_range(0, 19) == 0);
            fetch_en   = ($urandom_range(0, 9) < 8);
            fetch_stb  = ($urandom_range(0, 4) == 0);
            dram_rstrb = ($urandom_range(0, 9) < 3);
            dram_rdata = 16'($urandom);
            video_addr = 21'($urandom);
            fetch_sel  = 4'($urandom);
            fetch_bsl  = 2'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                per_sel  = $urandom_range(0, 2);
                need_sel = $urandom_range(0, 2);
                per_code  = (per_sel == 0) ? 2'b11 : ((per_sel == 1) ? 2'b01 : 2'b00);
                need_code = (need_sel == 0) ? 3'b001 : ((need_sel == 1) ? 3'b010 : 3'b100);
                video_bw  = {per_code, need_code};
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_fetch_sched.md
VIDEO_FETCH_SCHED -- requirements
Module: video_fetch_sched

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have port: res  input  1  synchronous active-high reset.
REQ-003 SHALL have port: c3  input  1  DRAM slot strobe, one video slot opportunity per asserted clk.
REQ-004 SHALL have port: line_start  input  1  start of fetch window for the current line.
REQ-005 SHALL have port: fetch_en  input  1  fetch window active.
REQ-006 SHALL have ports: video_bw  input  5  [4:3] period (11=8, 01=4, 00=2), [2:0] slots needed (001=1, 010=2, 100=4); video_addr  input  21  word address from mode decoder.
REQ-007 SHALL have ports: fetch_sel  input  4  byte-lane write enables; fetch_bsl  input  2  byte-source select; fetch_stb  input  1  transfer assembled word to renderer.
REQ-008 SHALL have ports: vid_req  output  1  DRAM read request; vid_addr  output  21  request address; video_next  output  1  one-clk pulse advancing column counter.
REQ-009 SHALL have ports: dram_rdata  input  16  returned word; dram_rstrb  input  1  returned word valid.
REQ-010 SHALL have ports: fetch_data  output  32  assembled data to renderer; bw_miss  output  1  one-clk pulse, slot skipped; rtn_err  output  1  sticky unexpected-return flag.

Function
REQ-011 Slot counter (3 bits) SHALL clear on line_start and increment on each c3 with fetch_en=1, wrapping 7->0; line_start wins over simultaneous c3.
REQ-012 Slot position SHALL be counter AND mask, mask = 7/3/1 for period 8/4/2.
REQ-013 Request slot SHALL be c3=1, fetch_en=1, line_start=0, position < need count (1/2/4); need > period (e.g. 4 of 2) SHALL request every slot.
REQ-014 In a request slot with tag FIFO not full, next clk SHALL show vid_req=1 for exactly one clk, vid_addr=video_addr sampled at the slot, video_next=1 same clk.
REQ-015 In a request slot with tag FIFO full, vid_req and video_next SHALL stay 0 and bw_miss SHALL pulse one clk later.
REQ-016 Tag FIFO: depth 4, entry {fetch_sel, fetch_bsl} sampled at request slot; push on issued request, pop on dram_rstrb.
REQ-017 Simultaneous push and pop SHALL leave occupancy unchanged and keep ordering; pop of the oldest entry SHALL precede the new one.
REQ-018 dram_rstrb with FIFO empty (and no same-clk push) SHALL be discarded, set rtn_err, leave assembly register unchanged.
REQ-019 On valid return, byte lanes 0 and 2 source = bsl[0] ? rdata[15:8] : rdata[7:0]; lanes 1 and 3 source = bsl[1] ? rdata[15:8] : rdata[7:0].
REQ-020 Assembly register byte n SHALL update only where sel[n]=1; other bytes hold; update visible next clk.
REQ-021 fetch_stb SHALL copy assembly register to fetch_data next clk; if a return lands same clk, fetch_data SHALL get the merged (post-return) value.
REQ-022 Assembly register SHALL not clear on fetch_stb or line_start.
REQ-023 fetch_en falling SHALL stop new requests; outstanding returns SHALL still be accepted and merged.
REQ-024 video_bw change mid-line SHALL take effect at the next c3 with no counter reset.

Reset
REQ-025 With res=1 at a clk edge: slot counter, FIFO occupancy, assembly register, fetch_data, vid_addr = 0; vid_req, video_next, bw_miss, rtn_err = 0.
REQ-026 res SHALL override all other inputs, including mid-request and mid-return; returns arriving while res=1 SHALL be dropped without setting rtn_err.
REQ-027 First request slot after reset SHALL require a fresh c3 with fetch_en=1.

Verification
REQ-028 video_bw=11_001 (1 of 8), fetch_en=1, c3 every clk, returns 2 clks after vid_req -> one vid_req per 8 c3, at positions 0, 8, 16; no bw_miss.
REQ-029 video_bw=11_100 (4 of 8), returns withheld -> 4 requests at positions 0-3, 5th request slot (position 0 of next period) produces bw_miss, no vid_req.
REQ-030 sel=0011 bsl=10, rdata=16'hA55A -> bytes[1:0]=A5 5A, bytes[3:2] held; then sel=0001 bsl=11, rdata=16'h1234 -> byte0=12.
REQ-031 dram_rstrb with empty FIFO -> rtn_err=1 sticky until res; fetch_data unchanged.
REQ-032 fetch_stb coincident with return of sel=1100 bsl=10 rdata=16'hBEEF onto register 0000_1111 -> fetch_data=BEEF_1111 next clk.
REQ-033 res asserted with 3 outstanding tags -> occupancy 0, outputs 0, a later return sets rtn_err=1.
